// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the iterative ALU.
//   alu_op_e    - 4-bit opcode encoding seen on the aluop port
//   alu_state_e - control FSM state encoding
//   CC_*        - bit positions of the {N,Z,C,V} condition codes
//   is_iterative() - opcodes handled by the multi-cycle mul/div datapath
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ILL0 = 4'b0000,
      OP_ADD  = 4'b0001,
      OP_SUB  = 4'b0010,
      OP_DIV  = 4'b0011,
      OP_MOD  = 4'b0100,
      OP_SHL  = 4'b0101,
      OP_SHAR = 4'b0110,
      OP_SHLR = 4'b0111,
      OP_RL   = 4'b1000,
      OP_RR   = 4'b1001,
      OP_ILLA = 4'b1010,
      OP_AND  = 4'b1011,
      OP_OR   = 4'b1100,
      OP_XOR  = 4'b1101,
      OP_NOT  = 4'b1110,
      OP_MUL  = 4'b1111
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } alu_state_e;

   localparam int unsigned CC_N = 3;
   localparam int unsigned CC_Z = 2;
   localparam int unsigned CC_C = 1;
   localparam int unsigned CC_V = 0;

   function automatic logic is_iterative(input alu_op_e op);
      return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
   endfunction

endpackage

// File: rtl/iter_muldiv.sv
// iter_muldiv: one-bit-per-cycle unsigned multiplier / restoring divider.
//   clk, reset     - clock, synchronous active-high reset
//   start_i        - load operands and begin WIDTH iterations
//   div_i          - 1: divide a_i by b_i, 0: multiply a_i by b_i
//   a_i, b_i       - operands (sampled on start_i)
//   done_o         - high during the final iteration; outputs valid then
//   product_o      - low WIDTH bits of a*b
//   prod_hi_nz_o   - high WIDTH bits of a*b are nonzero
//   quotient_o     - a / b   (all ones when b == 0)
//   remainder_o    - a % b   (a when b == 0)
module iter_muldiv #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   input  logic             div_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             done_o,
   output logic [WIDTH-1:0] product_o,
   output logic             prod_hi_nz_o,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o
);

   localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

   logic             busy_q, busy_d;
   logic             div_q, div_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   // hi: partial product high half / partial remainder
   // lo: multiplier shifting out, product low half / dividend shifting out, quotient in
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;

   logic [WIDTH-1:0] hi_step, lo_step;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   rem_sh;
   logic             rem_lt;

   always_comb begin
      mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
      rem_sh  = {hi_q, lo_q[WIDTH-1]};
      rem_lt  = rem_sh < {1'b0, m_q};
      if (div_q) begin
         // Difference always fits in WIDTH bits when rem_sh >= divisor.
         if (!rem_lt) begin
            hi_step = rem_sh[WIDTH-1:0] - m_q;
            lo_step = {lo_q[WIDTH-2:0], 1'b1};
         end else begin
            hi_step = rem_sh[WIDTH-1:0];
            lo_step = {lo_q[WIDTH-2:0], 1'b0};
         end
      end else begin
         hi_step = mul_sum[WIDTH:1];
         lo_step = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
   end

   // Outputs expose the final step combinationally so the caller can register
   // the result on the same edge as the last iteration.
   assign done_o       = busy_q && (cnt_q == CNT_LAST);
   assign product_o    = lo_step;
   assign prod_hi_nz_o = |hi_step;
   assign quotient_o   = lo_step;
   assign remainder_o  = hi_step;

   always_comb begin
      busy_d = busy_q;
      div_d  = div_q;
      cnt_d  = cnt_q;
      hi_d   = hi_q;
      lo_d   = lo_q;
      m_d    = m_q;
      if (start_i) begin
         busy_d = 1'b1;
         div_d  = div_i;
         cnt_d  = '0;
         hi_d   = '0;
         lo_d   = div_i ? a_i : b_i;
         m_d    = div_i ? b_i : a_i;
      end else if (busy_q) begin
         hi_d  = hi_step;
         lo_d  = lo_step;
         cnt_d = cnt_q + SHW'(1);
         if (cnt_q == CNT_LAST) begin
            busy_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q <= 1'b0;
         div_q  <= 1'b0;
         cnt_q  <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         m_q    <= '0;
      end else begin
         busy_q <= busy_d;
         div_q  <= div_d;
         cnt_q  <= cnt_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         m_q    <= m_d;
      end
   end

endmodule

// File: rtl/iter_alu.sv
// iter_alu: ALU with single-cycle logic/arith/shift ops and an iterative
// mul/div/mod path, valid/ready handshake on both sides.
//   clk, reset          - clock, synchronous active-high reset
//   in_valid / in_ready - request handshake (ready only in IDLE)
//   valA, valB, aluop   - operands and opcode, captured at accept
//   out_valid/out_ready - result handshake (valid in DONE)
//   result, cc          - registered result and {N,Z,C,V}
module iter_alu
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] valA,
   input  logic [WIDTH-1:0] valB,
   input  logic [3:0]       aluop,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       cc
);

   localparam int unsigned      MSB  = WIDTH - 1;
   localparam logic [WIDTH-1:0] WLIM = WIDTH'(WIDTH);

   alu_state_e       state_q, state_d;
   alu_op_e          op_in, op_q, op_d;
   logic             bzero_q, bzero_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [3:0]       cc_q, cc_d;

   logic             accept, md_start, md_done, md_hi_nz;
   logic [WIDTH-1:0] md_product, md_quotient, md_remainder;

   logic [WIDTH-1:0] sc_res, it_res;
   logic             sc_c, sc_v, it_c, it_v;
   logic [WIDTH:0]   add_ext, shl_ext;
   logic [SHW-1:0]   rot_amt;
   logic [SHW:0]     rot_inv;

   function automatic logic [3:0] make_cc(input logic [WIDTH-1:0] r, input logic c,
                                          input logic v);
      logic [3:0] f;
      f       = '0;
      f[CC_N] = r[MSB];
      f[CC_Z] = (r == '0);
      f[CC_C] = c;
      f[CC_V] = v;
      return f;
   endfunction

   assign op_in     = alu_op_e'(aluop);
   assign in_ready  = (state_q == ST_IDLE) && !reset;
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == ST_DONE);
   assign result    = result_q;
   assign cc        = cc_q;

   iter_muldiv #(
      .WIDTH(WIDTH),
      .SHW  (SHW)
   ) u_muldiv (
      .clk         (clk),
      .reset       (reset),
      .start_i     (md_start),
      .div_i       (op_in != OP_MUL),
      .a_i         (valA),
      .b_i         (valB),
      .done_o      (md_done),
      .product_o   (md_product),
      .prod_hi_nz_o(md_hi_nz),
      .quotient_o  (md_quotient),
      .remainder_o (md_remainder)
   );

   // Single-cycle ops evaluate the inputs at the accept edge, i.e. exactly
   // the operands being captured, so out_valid can follow one cycle later.
   always_comb begin
      sc_res  = '0;
      sc_c    = 1'b0;
      sc_v    = 1'b0;
      add_ext = '0;
      // Extra top bit of the left shift is the last bit shifted out.
      shl_ext = {1'b0, valA} << valB;
      rot_amt = valB[SHW-1:0];
      rot_inv = (SHW+1)'(WIDTH) - {1'b0, rot_amt};
      case (op_in)
         OP_ADD: begin
            add_ext = {1'b0, valA} + {1'b0, valB};
            sc_res  = add_ext[WIDTH-1:0];
            sc_c    = add_ext[WIDTH];
            sc_v    = (valA[MSB] == valB[MSB]) && (sc_res[MSB] != valA[MSB]);
         end
         OP_SUB: begin
            add_ext = {1'b0, valA} + {1'b0, ~valB} + (WIDTH+1)'(1);
            sc_res  = add_ext[WIDTH-1:0];
            sc_c    = add_ext[WIDTH];
            sc_v    = (valA[MSB] != valB[MSB]) && (sc_res[MSB] != valA[MSB]);
         end
         OP_SHL: begin
            sc_res = shl_ext[WIDTH-1:0];
            sc_c   = shl_ext[WIDTH];
            sc_v   = (sc_res[MSB] != valA[MSB]);
         end
         OP_SHLR: sc_res = valA >> valB;
         OP_SHAR: begin
            if (valB >= WLIM) sc_res = {WIDTH{valA[MSB]}};
            else              sc_res = $signed(valA) >>> rot_amt;
         end
         OP_RL:   sc_res = (valA << rot_amt) | (valA >> rot_inv);
         OP_RR:   sc_res = (valA >> rot_amt) | (valA << rot_inv);
         OP_AND:  sc_res = valA & valB;
         OP_OR:   sc_res = valA | valB;
         OP_XOR:  sc_res = valA ^ valB;
         OP_NOT:  sc_res = ~valB;
         default: ;
      endcase
   end

   always_comb begin
      it_res = md_quotient;
      it_c   = 1'b0;
      it_v   = bzero_q;
      case (op_q)
         OP_MUL: begin
            it_res = md_product;
            it_c   = md_hi_nz;
            it_v   = 1'b0;
         end
         OP_MOD:  it_res = md_remainder;
         default: ;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      bzero_d  = bzero_q;
      result_d = result_q;
      cc_d     = cc_q;
      md_start = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               op_d    = op_in;
               bzero_d = (valB == '0);
               if (is_iterative(op_in)) begin
                  md_start = 1'b1;
                  state_d  = ST_BUSY;
               end else begin
                  state_d  = ST_DONE;
                  result_d = sc_res;
                  cc_d     = make_cc(sc_res, sc_c, sc_v);
               end
            end
         end
         ST_BUSY: begin
            if (md_done) begin
               state_d  = ST_DONE;
               result_d = it_res;
               cc_d     = make_cc(it_res, it_c, it_v);
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         op_q     <= OP_ILL0;
         bzero_q  <= 1'b0;
         result_q <= '0;
         cc_q     <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         bzero_q  <= bzero_d;
         result_q <= result_d;
         cc_q     <= cc_d;
      end
   end

endmodule

// File: tb/tb_iter_alu.sv
// tb_iter_alu: directed self-checking bench for iter_alu at WIDTH=16 and WIDTH=8.
module tb_iter_alu;
   import alu_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        v16, ir16, ov16, or16;
   logic [15:0] a16, b16, r16;
   logic [3:0]  op16, cc16;
   logic        v8, ir8, ov8, or8;
   logic [7:0]  a8, b8, r8;
   logic [3:0]  op8, cc8;

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic [3:0]  cc;
   } v16_t;

   typedef struct packed {
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic [3:0] cc;
      logic [7:0] lat;
   } v8_t;

   iter_alu #(.WIDTH(16)) u16 (
      .clk(clk), .reset(rst), .in_valid(v16), .in_ready(ir16), .valA(a16), .valB(b16),
      .aluop(op16), .out_valid(ov16), .out_ready(or16), .result(r16), .cc(cc16)
   );

   iter_alu #(.WIDTH(8)) u8 (
      .clk(clk), .reset(rst), .in_valid(v8), .in_ready(ir8), .valA(a8), .valB(b8),
      .aluop(op8), .out_valid(ov8), .out_ready(or8), .result(r8), .cc(cc8)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Issue one request from IDLE and wait (bounded) for out_valid.
   // lat = cycles from accept to out_valid; rdy_cnt = cycles in_ready seen while waiting.
   task automatic issue16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          output int lat, output int rdy_cnt);
      op16 = op; a16 = a; b16 = b; v16 = 1'b1;
      @(posedge clk); #1;
      v16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); op16 = 4'($urandom);
      lat = 1; rdy_cnt = 0;
      while (!ov16 && lat < 64) begin
         if (ir16) rdy_cnt++;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic release16;
      or16 = 1'b1;
      @(posedge clk); #1;
      or16 = 1'b0;
   endtask

   task automatic issue8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         output int lat);
      op8 = op; a8 = a; b8 = b; v8 = 1'b1;
      @(posedge clk); #1;
      v8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      lat = 1;
      while (!ov8 && lat < 64) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic release8;
      or8 = 1'b1;
      @(posedge clk); #1;
      or8 = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      v16 = 1'b0; or16 = 1'b0; a16 = '0; b16 = '0; op16 = '0;
      v8  = 1'b0; or8  = 1'b0; a8  = '0; b8  = '0; op8  = '0;
      repeat (3) @(posedge clk);
      #1;
      tests++; if (r16 !== 16'h0000) begin fails++; $display("FAIL reset_result: got %h want 0000", r16); end
      tests++; if (cc16 !== 4'b0000) begin fails++; $display("FAIL reset_cc: got %b want 0000", cc16); end
      tests++; if (ov16 !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", ov16); end
      tests++; if (ir16 !== 1'b0) begin fails++; $display("FAIL reset_in_ready_during: got %b want 0", ir16); end
      tests++; if (r8 !== 8'h00 || ov8 !== 1'b0) begin fails++; $display("FAIL reset_w8: got %h/%b want 00/0", r8, ov8); end
      rst = 1'b0;
      #1;
      tests++; if (ir16 !== 1'b1) begin fails++; $display("FAIL reset_in_ready_after: got %b want 1", ir16); end
   endtask

   task automatic test_single16;
      v16_t tv [18];
      int lat, rdy;
      tv = '{
         '{OP_ADD,  16'h7FFF, 16'h0001, 16'h8000, 4'b1001},
         '{OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 4'b0110},
         '{OP_SUB,  16'h0005, 16'h0003, 16'h0002, 4'b0010},
         '{OP_SUB,  16'h8000, 16'h0001, 16'h7FFF, 4'b0011},
         '{OP_SUB,  16'h0000, 16'h0001, 16'hFFFF, 4'b1000},
         '{OP_AND,  16'hF0F0, 16'hFF00, 16'hF000, 4'b1000},
         '{OP_OR,   16'h0F00, 16'h00F0, 16'h0FF0, 4'b0000},
         '{OP_XOR,  16'hAAAA, 16'hAAAA, 16'h0000, 4'b0100},
         '{OP_NOT,  16'h1234, 16'h00FF, 16'hFF00, 4'b1000},
         '{OP_SHL,  16'h4001, 16'h0001, 16'h8002, 4'b1001},
         '{OP_SHL,  16'h8001, 16'h0010, 16'h0000, 4'b0111},
         '{OP_SHL,  16'h8001, 16'h0011, 16'h0000, 4'b0101},
         '{OP_SHL,  16'h1234, 16'h0000, 16'h1234, 4'b0000},
         '{OP_SHAR, 16'h8000, 16'h0004, 16'hF800, 4'b1000},
         '{OP_RR,   16'h0001, 16'h0001, 16'h8000, 4'b1000},
         '{OP_RL,   16'h8001, 16'h0011, 16'h0003, 4'b0000},
         '{OP_ILL0, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b0100},
         '{OP_ILLA, 16'h1234, 16'h5678, 16'h0000, 4'b0100}
      };
      for (int i = 0; i < 18; i++) begin
         issue16(tv[i].op, tv[i].a, tv[i].b, lat, rdy);
         tests++; if (lat != 1) begin fails++; $display("FAIL single_lat[%0d]: got %0d want 1", i, lat); end
         tests++; if (r16 !== tv[i].res) begin fails++; $display("FAIL single_res[%0d]: got %h want %h", i, r16, tv[i].res); end
         tests++; if (cc16 !== tv[i].cc) begin fails++; $display("FAIL single_cc[%0d]: got %b want %b", i, cc16, tv[i].cc); end
         release16();
      end
   endtask

   task automatic test_muldiv16;
      v16_t tv [8];
      int lat, rdy;
      tv = '{
         '{OP_MUL, 16'h0100, 16'h0100, 16'h0000, 4'b0110},
         '{OP_MUL, 16'h0003, 16'h0005, 16'h000F, 4'b0000},
         '{OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b0010},
         '{OP_DIV, 16'h0064, 16'h0000, 16'hFFFF, 4'b1001},
         '{OP_MOD, 16'h0064, 16'h0007, 16'h0002, 4'b0000},
         '{OP_DIV, 16'h0064, 16'h0007, 16'h000E, 4'b0000},
         '{OP_MOD, 16'h0064, 16'h0000, 16'h0064, 4'b0001},
         '{OP_DIV, 16'hFFFF, 16'h0003, 16'h5555, 4'b0000}
      };
      for (int i = 0; i < 8; i++) begin
         issue16(tv[i].op, tv[i].a, tv[i].b, lat, rdy);
         tests++; if (lat != 17) begin fails++; $display("FAIL iter_lat[%0d]: got %0d want 17", i, lat); end
         tests++; if (rdy != 0) begin fails++; $display("FAIL iter_in_ready[%0d]: got %0d ready cycles want 0", i, rdy); end
         tests++; if (r16 !== tv[i].res) begin fails++; $display("FAIL iter_res[%0d]: got %h want %h", i, r16, tv[i].res); end
         tests++; if (cc16 !== tv[i].cc) begin fails++; $display("FAIL iter_cc[%0d]: got %b want %b", i, cc16, tv[i].cc); end
         release16();
      end
   endtask

   task automatic test_width8;
      v8_t tv [7];
      int lat;
      tv = '{
         '{OP_SHAR, 8'h80, 8'h09, 8'hFF, 4'b1000, 8'd1},
         '{OP_RL,   8'h81, 8'h09, 8'h03, 4'b0000, 8'd1},
         '{OP_SHLR, 8'h80, 8'h08, 8'h00, 4'b0100, 8'd1},
         '{OP_RR,   8'h81, 8'h01, 8'hC0, 4'b1000, 8'd1},
         '{OP_SHL,  8'h81, 8'h08, 8'h00, 4'b0111, 8'd1},
         '{OP_MUL,  8'h10, 8'h10, 8'h00, 4'b0110, 8'd9},
         '{OP_DIV,  8'h10, 8'h00, 8'hFF, 4'b1001, 8'd9}
      };
      for (int i = 0; i < 7; i++) begin
         issue8(tv[i].op, tv[i].a, tv[i].b, lat);
         tests++; if (lat != int'(tv[i].lat)) begin fails++; $display("FAIL w8_lat[%0d]: got %0d want %0d", i, lat, tv[i].lat); end
         tests++; if (r8 !== tv[i].res) begin fails++; $display("FAIL w8_res[%0d]: got %h want %h", i, r8, tv[i].res); end
         tests++; if (cc8 !== tv[i].cc) begin fails++; $display("FAIL w8_cc[%0d]: got %b want %b", i, cc8, tv[i].cc); end
         release8();
      end
   endtask

   task automatic test_backpressure;
      int lat, rdy, bad, extra;
      issue16(OP_ADD, 16'h0003, 16'h0004, lat, rdy);
      tests++; if (lat != 1 || r16 !== 16'h0007) begin fails++; $display("FAIL bp_first: got lat %0d res %h want 1/0007", lat, r16); end
      bad = 0;
      v16 = 1'b1; op16 = OP_SUB; a16 = 16'h1111; b16 = 16'h2222;
      repeat (5) begin
         @(posedge clk); #1;
         if (ov16 !== 1'b1 || r16 !== 16'h0007 || cc16 !== 4'b0000 || ir16 !== 1'b0) bad++;
      end
      tests++; if (bad != 0) begin fails++; $display("FAIL bp_stable: got %0d unstable cycles want 0", bad); end
      or16 = 1'b1;
      @(posedge clk); #1;
      or16 = 1'b0; v16 = 1'b0;
      tests++; if (ov16 !== 1'b0 || ir16 !== 1'b1) begin fails++; $display("FAIL bp_release: got ov %b ir %b want 0/1", ov16, ir16); end
      extra = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (ov16 !== 1'b0) extra++;
      end
      tests++; if (extra != 0) begin fails++; $display("FAIL bp_single_completion: got %0d extra valid cycles want 0", extra); end
   endtask

   task automatic test_reset_busy;
      int lat, rdy, seen;
      op16 = OP_DIV; a16 = 16'd100; b16 = 16'd7; v16 = 1'b1;
      @(posedge clk); #1;
      v16 = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      tests++; if (ov16 !== 1'b0 || ir16 !== 1'b0) begin fails++; $display("FAIL rb_busy: got ov %b ir %b want 0/0", ov16, ir16); end
      rst = 1'b1;
      @(posedge clk); #1;
      tests++; if (r16 !== 16'h0000 || cc16 !== 4'b0000 || ov16 !== 1'b0) begin
         fails++; $display("FAIL rb_cleared: got res %h cc %b ov %b want 0000/0000/0", r16, cc16, ov16);
      end
      tests++; if (ir16 !== 1'b0) begin fails++; $display("FAIL rb_in_ready_reset: got %b want 0", ir16); end
      rst = 1'b0;
      seen = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (ov16 !== 1'b0) seen++;
      end
      tests++; if (seen != 0) begin fails++; $display("FAIL rb_no_valid: got %0d valid cycles want 0", seen); end
      issue16(OP_ADD, 16'h0003, 16'h0004, lat, rdy);
      tests++; if (lat != 1) begin fails++; $display("FAIL rb_add_lat: got %0d want 1", lat); end
      tests++; if (r16 !== 16'h0007 || cc16 !== 4'b0000) begin
         fails++; $display("FAIL rb_add: got %h/%b want 0007/0000", r16, cc16);
      end
      release16();
   endtask

   initial begin
      test_reset();
      test_single16();
      test_muldiv16();
      test_width8();
      test_backpressure();
      test_reset_busy();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/iter_alu.md
ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width; legal values 4..64, power of two.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width; not overridden by instantiators.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operation request present.
REQ-006 in_ready  output  1  block accepts request this cycle.
REQ-007 valA  input  WIDTH  operand A; data operand for shifts/rotates.
REQ-008 valB  input  WIDTH  operand B; shift/rotate amount; divisor.
REQ-009 aluop  input  4  opcode, encoding per shared package.
REQ-010 out_valid  output  1  result and cc valid.
REQ-011 out_ready  input  1  consumer takes result this cycle.
REQ-012 result  output  WIDTH  registered result.
REQ-013 cc  output  4  registered flags {N,Z,C,V}.

Function
REQ-014 Opcodes: ADD 0001, SUB 0010, DIV 0011, MOD 0100, SHL 0101, SHAR 0110, SHLR 0111, RL 1000, RR 1001, AND 1011, OR 1100, XOR 1101, NOT 1110, MUL 1111; 0000 and 1010 illegal.
REQ-015 FSM states IDLE, BUSY, DONE; in_ready = 1 only in IDLE and not in reset.
REQ-016 Accept = in_valid & in_ready; operands and opcode captured at accept; later input changes ignored.
REQ-017 IDLE: accept of MUL/DIV/MOD -> BUSY; accept of any other opcode -> DONE with result computed; no accept -> IDLE.
REQ-018 BUSY: one iteration per cycle, counter 0..WIDTH-1; after WIDTH iterations -> DONE.
REQ-019 Latency: out_valid rises 1 cycle after accept for single-cycle ops, WIDTH+1 cycles after accept for MUL/DIV/MOD.
REQ-020 DONE: out_valid = 1, result/cc held stable; out_ready = 1 -> IDLE next cycle; next accept no earlier than cycle after that.
REQ-021 ADD: A+B mod 2^WIDTH; SUB: A+~B+1; C = carry out of MSB (SUB: C=1 means no borrow); V = signed overflow.
REQ-022 MUL: unsigned shift-add, result = low WIDTH bits of product; C = 1 if high half nonzero; V = 0.
REQ-023 DIV/MOD: unsigned restoring division; DIV returns quotient, MOD remainder; C = 0.
REQ-024 Divide by zero: DIV result all ones, MOD result = A, V = 1; still takes WIDTH+1 cycles.
REQ-025 Shifts: amount = valB; SHL/SHLR amount >= WIDTH -> 0; SHAR amount >= WIDTH -> all bits = A[MSB].
REQ-026 RL/RR: amount taken modulo WIDTH (valB[SHW-1:0]).
REQ-027 SHL: C = last bit shifted out (0 if amount 0 or >= WIDTH+1), V = 1 if result sign differs from A sign; other shifts/rotates/logic: C = 0, V = 0.
REQ-028 AND/OR/XOR bitwise on A,B; NOT = ~B.
REQ-029 N = result[WIDTH-1]; Z = (result == 0) for every opcode.
REQ-030 Illegal opcode: single-cycle, result = 0, cc = 0100.

Reset
REQ-031 reset high at a clock edge forces IDLE, counter 0, result 0, cc 0000, out_valid 0, regardless of state.
REQ-032 reset asserted mid-BUSY or in DONE discards the operation; no out_valid for it follows.
REQ-033 in_ready = 0 while reset is high; 1 in the first cycle after reset deasserts.

Structure
REQ-034 Shared package alu_pkg holds opcode constants, FSM state encoding, cc bit indices (N=3,Z=2,C=1,V=0).
REQ-035 Iterative multiply/divide datapath is sub-module iter_muldiv (start, op, operands, done, product/quotient/remainder), parameterised by WIDTH.
REQ-036 Single-cycle ops are combinational from captured operands into the result register.

Verification
REQ-037 WIDTH=16: ADD 0x7FFF+0x0001 -> result 0x8000, cc 1001, out_valid 1 cycle after accept.
REQ-038 WIDTH=16: MUL 0x0100*0x0100 -> result 0x0000, cc 0110, out_valid 17 cycles after accept; in_ready 0 throughout.
REQ-039 WIDTH=16: DIV 100/0 -> result 0xFFFF, cc 1001; MOD 100/7 -> result 0x0002, cc 0000.
REQ-040 WIDTH=8: SHAR 0x80 by 9 -> 0xFF; RL 0x81 by 9 -> 0x03; SHLR 0x80 by 8 -> 0x00, cc 0100.
REQ-041 Backpressure: hold out_ready 0 for 5 cycles in DONE -> result/cc/out_valid stable, in_valid ignored, one completion only.
REQ-042 reset pulse at BUSY iteration 7 of DIV -> outputs 0, no out_valid, next ADD 3+4 -> result 0x0007.
